ex_muldiv: RTL and testbench
============================

# ex_muldiv

Multi-cycle RV32M multiply/divide execute unit. It sits beside the single-cycle ALU in the EX stage and takes the same register operands and destination-write fields. While it works it holds the pipeline through a stall request. It generalises the EX arithmetic path in width (XLEN) and in iteration rate (UNROLL), and adds sequential MUL/MULH*/DIV*/REM* behaviour that the ALU does not have.

## Interface
- XLEN, 32, datapath width; must be a multiple of UNROLL.
- UNROLL, 1, result bits resolved per CALC cycle; one of 1, 2, 4.
- REGADDR_W, 5, destination register address width.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  request to execute op_i on the operands this cycle.
- op_i  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- reg1_i  in  XLEN  rs1 value (dividend / multiplicand).
- reg2_i  in  XLEN  rs2 value (divisor / multiplier).
- wd_i  in  REGADDR_W  destination register.
- wreg_i  in  1  write-enable carried with the op.
- flush_i  in  1  branch/jump discard; aborts any op in flight.
- stall_req_o  out  1  hold IF/ID/EX; combinational.
- done_o  out  1  one-cycle result-valid pulse, registered.
- wdata_o  out  XLEN  result; valid only when done_o=1.
- wd_o  out  REGADDR_W  latched wd_i; valid when done_o=1.
- wreg_o  out  1  latched wreg_i AND done_o.

## Operation
- Reset: state IDLE; done_o, wdata_o, wd_o, wreg_o are all 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE: if start_i=1 and flush_i=0, latch the operands, op, wd and wreg, then:
  - divide by zero, or signed overflow (DIV/REM with reg1=-2^(XLEN-1), reg2=-1): go to DONE (fast path);
  - otherwise load the iteration counter with XLEN/UNROLL and go to CALC.
- Operand conditioning at accept:
  - take magnitudes of signed operands (MULH: both; MULHSU: rs1 only; DIV/REM: both);
  - record the negate flag: product and quotient = s1^s2; remainder = s1.
- CALC: unsigned shift-add multiply into a 2·XLEN accumulator, or restoring division, UNROLL bits per cycle. Decrement the counter; go to FIX when it reaches 1.
- FIX: two's-complement negate the result if the negate flag is set, then go to DONE.
- Result select:
  - MUL: low XLEN bits;
  - MULH, MULHSU, MULHU: high XLEN bits;
  - DIV, DIVU: quotient;
  - REM, REMU: remainder.
- Fast-path results:
  - divide by zero: quotient = all ones, remainder = reg1;
  - overflow: quotient = -2^(XLEN-1), remainder = 0.
- DONE: done_o=1 for exactly one cycle, then go to IDLE. A start_i in DONE is ignored; the ID stage re-presents it, because the stall holds.
- stall_req_o = (IDLE & start_i & !flush_i) | CALC | FIX. It is 0 in DONE, which releases the pipeline on the result cycle.
- flush_i=1 in any state: go to IDLE next cycle, no done_o, outputs return to 0. flush_i has priority over start_i.
- Operand inputs are ignored outside an accepting IDLE cycle.

## Timing
- Define N = XLEN/UNROLL. Accept at edge T, when start_i is sampled in IDLE.
- Normal path: CALC covers cycles T+1..T+N, FIX is T+N+1, done_o is high in T+N+2. Latency is N+2; with defaults that is 34.
- Fast path: done_o is high in T+1.
- Back-to-back ops: the earliest next accept is the cycle after DONE, so throughput is one op per N+3 cycles.
- rst mid-operation: IDLE and zeroed outputs at the next edge, no done_o. A start_i that coincides with rst is dropped.

## Test plan
- MUL 7 × -3, XLEN=32, UNROLL=1 -> done_o at T+34, wdata_o=0xFFFFFFEB, stall_req_o high for 34 cycles.
- MULH 0x80000000 × 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1 × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF at T+1; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000 at T+1; REM 0x80000000/-1 -> 0.
- flush_i at T+10 of a DIV -> IDLE at T+11, done_o never asserted. Same for rst at T+10.
- UNROLL=4: DIVU 0xFFFFFFFF/3 -> 0x55555555 at T+10. A second start_i held from DONE is accepted the cycle after DONE, and wd_o/wreg_o track each op.

Source files
------------

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit: N=XLEN/UNROLL CALC cycles + FIX, done_o at accept+N+2 (fast path +1).
// Backpressure: stall_req_o holds the pipeline from accept until the DONE cycle releases it.
module ex_muldiv #(
  parameter int XLEN      = 32,
  parameter int UNROLL    = 1,
  parameter int REGADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [2:0]           op_i,
  input  logic [XLEN-1:0]      reg1_i,
  input  logic [XLEN-1:0]      reg2_i,
  input  logic [REGADDR_W-1:0] wd_i,
  input  logic                 wreg_i,
  input  logic                 flush_i,
  output logic                 stall_req_o,
  output logic                 done_o,
  output logic [XLEN-1:0]      wdata_o,
  output logic [REGADDR_W-1:0] wd_o,
  output logic                 wreg_o
);

  localparam int N     = XLEN / UNROLL;
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]        hi_q, lo_q, opnd_q;
  logic [2:0]             op_q;
  logic                   neg_q;
  logic [REGADDR_W-1:0]   wd_q;
  logic                   wreg_q;

  logic                   load;
  logic                   done_d;
  logic [XLEN-1:0]        res_d;
  logic [REGADDR_W-1:0]   wd_d;
  logic                   wreg_d;

  // Operand conditioning at accept
  logic                   s1, s2, neg_in;
  logic [XLEN-1:0]        abs1, abs2;
  logic                   div_zero, div_ovf;
  logic [XLEN-1:0]        fast_res;

  always_comb begin
    s1 = reg1_i[XLEN-1] & (op_i == OP_MULH || op_i == OP_MULHSU || op_i == OP_DIV || op_i == OP_REM);
    s2 = reg2_i[XLEN-1] & (op_i == OP_MULH || op_i == OP_DIV || op_i == OP_REM);
    abs1 = s1 ? (~reg1_i + 1'b1) : reg1_i;
    abs2 = s2 ? (~reg2_i + 1'b1) : reg2_i;
    case (op_i)
      OP_MULH, OP_DIV: neg_in = s1 ^ s2;
      OP_MULHSU, OP_REM: neg_in = s1;
      default: neg_in = 1'b0;
    endcase
    div_zero = op_i[2] && (reg2_i == '0);
    div_ovf  = (op_i == OP_DIV || op_i == OP_REM) && (reg1_i == XMIN) && (reg2_i == '1);
    if (div_zero) fast_res = op_i[1] ? reg1_i : '1;
    else          fast_res = op_i[1] ? '0 : XMIN;
  end

  // One CALC cycle: UNROLL shift-add or restoring-divide steps on {hi, lo}
  logic [XLEN-1:0] it_hi, it_lo;
  logic [XLEN:0]   sum, rem_sh;

  always_comb begin
    it_hi  = hi_q;
    it_lo  = lo_q;
    sum    = '0;
    rem_sh = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (!op_q[2]) begin
        sum = {1'b0, it_hi} + (it_lo[0] ? {1'b0, opnd_q} : '0);
        {it_hi, it_lo} = {sum, it_lo[XLEN-1:1]};
      end else begin
        rem_sh = {it_hi, it_lo[XLEN-1]};
        it_lo  = {it_lo[XLEN-2:0], 1'b0};
        if (rem_sh >= {1'b0, opnd_q}) begin
          rem_sh   = rem_sh - {1'b0, opnd_q};
          it_lo[0] = 1'b1;
        end
        it_hi = rem_sh[XLEN-1:0];
      end
    end
  end

  // Sign fix-up: products are negated across the full 2*XLEN width so MULH borrows correctly
  logic [2*XLEN-1:0] prod, prod_n;
  logic [XLEN-1:0]   div_r, div_n, calc_res;

  always_comb begin
    prod   = {hi_q, lo_q};
    prod_n = neg_q ? (~prod + 1'b1) : prod;
    div_r  = op_q[1] ? hi_q : lo_q;
    div_n  = neg_q ? (~div_r + 1'b1) : div_r;
    if (op_q[2])              calc_res = div_n;
    else if (op_q == OP_MUL)  calc_res = prod_n[XLEN-1:0];
    else                      calc_res = prod_n[2*XLEN-1:XLEN];
  end

  assign stall_req_o = ((state_q == S_IDLE) && start_i && !flush_i) ||
                       (state_q == S_CALC) || (state_q == S_FIX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    done_d  = 1'b0;
    res_d   = '0;
    wd_d    = '0;
    wreg_d  = 1'b0;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            load = 1'b1;
            if (div_zero || div_ovf) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              res_d   = fast_res;
              wd_d    = wd_i;
              wreg_d  = wreg_i;
            end else begin
              state_d = S_CALC;
              cnt_d   = CNT_W'(N);
            end
          end
        end
        S_CALC: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        end
        S_FIX: begin
          state_d = S_DONE;
          done_d  = 1'b1;
          res_d   = calc_res;
          wd_d    = wd_q;
          wreg_d  = wreg_q;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      done_o  <= 1'b0;
      wdata_o <= '0;
      wd_o    <= '0;
      wreg_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_o  <= done_d;
      wdata_o <= res_d;
      wd_o    <= wd_d;
      wreg_o  <= wreg_d;
      if (load) begin
        hi_q   <= '0;
        lo_q   <= op_i[2] ? abs1 : abs2;
        opnd_q <= op_i[2] ? abs2 : abs1;
        op_q   <= op_i;
        neg_q  <= neg_in;
        wd_q   <= wd_i;
        wreg_q <= wreg_i;
      end else if (state_q == S_CALC) begin
        hi_q <= it_hi;
        lo_q <= it_lo;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: UNROLL=1 and UNROLL=4 instances checked against an arithmetic reference model.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0, start4 = 1'b0, flush = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] r1 = '0, r2 = '0;
  logic [4:0]  wd = '0;
  logic        wreg = 1'b0;

  logic        stall1, done1, wreg1, stall4, done4, wreg4;
  logic [31:0] wdata1, wdata4;
  logic [4:0]  wd1, wd4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32), .UNROLL(1), .REGADDR_W(5)) dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .op_i(op), .reg1_i(r1), .reg2_i(r2),
    .wd_i(wd), .wreg_i(wreg), .flush_i(flush), .stall_req_o(stall1), .done_o(done1),
    .wdata_o(wdata1), .wd_o(wd1), .wreg_o(wreg1));

  ex_muldiv #(.XLEN(32), .UNROLL(4), .REGADDR_W(5)) dut4 (
    .clk(clk), .rst(rst), .start_i(start4), .op_i(op), .reg1_i(r1), .reg2_i(r2),
    .wd_i(wd), .wreg_i(wreg), .flush_i(flush), .stall_req_o(stall4), .done_o(done4),
    .wdata_o(wdata4), .wd_o(wd4), .wreg_o(wreg4));

  // Reference: RV32M semantics via 64-bit arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      3'd0: p = {32'b0, a} * {32'b0, b};
      3'd1: begin p = sa * sb; p = p >> 32; end
      3'd2: begin p = sa * longint'({32'b0, b}); p = p >> 32; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; p = p >> 32; end
      3'd4: if (b == 0) p = '1; else if (a == 32'h8000_0000 && b == '1) p = 64'h8000_0000; else p = sa / sb;
      3'd5: if (b == 0) p = '1; else p = {32'b0, a} / {32'b0, b};
      3'd6: if (b == 0) p = {32'b0, a}; else if (a == 32'h8000_0000 && b == '1) p = '0; else p = sa % sb;
      default: if (b == 0) p = {32'b0, a}; else p = {32'b0, a} % {32'b0, b};
    endcase
    return p[31:0];
  endfunction

  function automatic int ref_lat(input int u, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == '1))) return 1;
    return 32 / u + 2;
  endfunction

  // Issues one op; reports result, latency in cycles after the accept edge, and stall-high cycle count.
  task automatic run_op(input int u, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] w, input logic we, output logic [31:0] res,
                        output logic [4:0] owd, output logic owe, output int lat, output int stalls);
    logic found;
    @(negedge clk);
    op = f; r1 = a; r2 = b; wd = w; wreg = we;
    if (u == 1) start1 = 1'b1; else start4 = 1'b1;
    #1;
    stalls = ((u == 1) ? stall1 : stall4) ? 1 : 0;
    @(posedge clk);
    #1;
    start1 = 1'b0; start4 = 1'b0;
    op = 3'($urandom); r1 = $urandom; r2 = $urandom; wd = 5'($urandom); wreg = 1'($urandom);
    res = '0; owd = '0; owe = 1'b0; lat = 0; found = 1'b0;
    while (!found && lat < 200) begin
      @(negedge clk);
      lat++;
      if ((u == 1) ? done1 : done4) begin
        found = 1'b1;
        res = (u == 1) ? wdata1 : wdata4;
        owd = (u == 1) ? wd1 : wd4;
        owe = (u == 1) ? wreg1 : wreg4;
      end else if ((u == 1) ? stall1 : stall4) begin
        stalls++;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (done1 !== 1'b0 || wdata1 !== '0 || wd1 !== '0 || wreg1 !== 1'b0) begin
      failures++; $display("FAIL reset_u1 got done=%b wdata=%h wd=%h wreg=%b want all zero", done1, wdata1, wd1, wreg1); end
    checks++; if (done4 !== 1'b0 || wdata4 !== '0 || wd4 !== '0 || wreg4 !== 1'b0) begin
      failures++; $display("FAIL reset_u4 got done=%b wdata=%h wd=%h wreg=%b want all zero", done4, wdata4, wd4, wreg4); end
    checks++; if (stall1 !== 1'b0 || stall4 !== 1'b0) begin
      failures++; $display("FAIL reset_stall got %b/%b want 0/0", stall1, stall4); end
    rst = 1'b0;
  endtask

  typedef struct { int u; logic [2:0] f; logic [31:0] a; logic [31:0] b; logic [31:0] exp; int lat; } vec_t;

  task automatic test_directed();
    vec_t v[14];
    logic [31:0] res; logic [4:0] owd; logic owe; int lat, st;
    v[0]  = '{1, 3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    v[1]  = '{4, 3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 10};
    v[2]  = '{4, 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 10};
    v[3]  = '{4, 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 10};
    v[4]  = '{4, 3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 10};
    v[5]  = '{4, 3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 10};
    v[6]  = '{4, 3'd5, 32'd100,        32'd7,         32'd14,        10};
    v[7]  = '{4, 3'd7, 32'd100,        32'd7,         32'd2,         10};
    v[8]  = '{4, 3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    v[9]  = '{4, 3'd6, 32'd5,          32'd0,         32'd5,         1};
    v[10] = '{1, 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    v[11] = '{4, 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    v[12] = '{4, 3'd5, 32'hFFFF_FFFF,  32'd3,         32'h5555_5555, 10};
    v[13] = '{1, 3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
    foreach (v[i]) begin
      run_op(v[i].u, v[i].f, v[i].a, v[i].b, 5'(i + 1), 1'b1, res, owd, owe, lat, st);
      checks++; if (res !== v[i].exp) begin
        failures++; $display("FAIL dir%0d_result got %h want %h", i, res, v[i].exp); end
      checks++; if (lat != v[i].lat) begin
        failures++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, v[i].lat); end
      checks++; if (owd !== 5'(i + 1) || owe !== 1'b1) begin
        failures++; $display("FAIL dir%0d_wd got %0d/%b want %0d/1", i, owd, owe, i + 1); end
      checks++; if (st != v[i].lat) begin
        failures++; $display("FAIL dir%0d_stall_cycles got %0d want %0d", i, st, v[i].lat); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res; logic [2:0] f; logic [4:0] w, owd; logic we, owe; int u, lat, st;
    logic [31:0] corner [5];
    corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF;
    for (int i = 0; i < 48; i++) begin
      u  = (i % 8 == 0) ? 1 : 4;
      f  = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      if (i % 5 == 4) b = 32'($urandom_range(0, 9));
      w  = 5'($urandom); we = 1'($urandom);
      run_op(u, f, a, b, w, we, res, owd, owe, lat, st);
      checks++; if (res !== ref_res(f, a, b) || lat != ref_lat(u, f, a, b) || owd !== w || owe !== we) begin
        failures++;
        $display("FAIL rand%0d u=%0d op=%0d a=%h b=%h got res=%h lat=%0d wd=%0d wreg=%b want res=%h lat=%0d wd=%0d wreg=%b",
                 i, u, f, a, b, res, lat, owd, owe, ref_res(f, a, b), ref_lat(u, f, a, b), w, we);
      end
    end
  endtask

  // Abort a UNROLL=1 DIV at T+10 via flush (use_rst=0) or rst (use_rst=1).
  task automatic abort_mid(input logic use_rst);
    int nd;
    @(negedge clk);
    op = 3'd4; r1 = 32'hFFFF_FF9C; r2 = 32'd7; wd = 5'd4; wreg = 1'b1; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (stall1 !== 1'b1) begin
      failures++; $display("FAIL abort%0d_busy got stall=%b want 1", use_rst, stall1); end
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; flush = 1'b0;
    @(negedge clk);
    checks++; if (stall1 !== 1'b0 || done1 !== 1'b0 || wdata1 !== '0 || wreg1 !== 1'b0) begin
      failures++; $display("FAIL abort%0d_idle got stall=%b done=%b wdata=%h wreg=%b want 0/0/0/0",
                           use_rst, stall1, done1, wdata1, wreg1); end
    nd = 0;
    repeat (40) begin @(negedge clk); if (done1) nd++; end
    checks++; if (nd != 0) begin
      failures++; $display("FAIL abort%0d_no_done got %0d done pulses want 0", use_rst, nd); end
  endtask

  task automatic test_flush();
    logic [31:0] res; logic [4:0] owd; logic owe; int lat, st, nd;
    abort_mid(1'b0);
    @(negedge clk);
    op = 3'd5; r1 = 32'd100; r2 = 32'd7; flush = 1'b1; start1 = 1'b1; start4 = 1'b1;
    #1;
    checks++; if (stall1 !== 1'b0 || stall4 !== 1'b0) begin
      failures++; $display("FAIL flush_prio_stall got %b/%b want 0/0", stall1, stall4); end
    @(posedge clk);
    #1 flush = 1'b0; start1 = 1'b0; start4 = 1'b0;
    nd = 0;
    repeat (40) begin @(negedge clk); if (done1 || done4) nd++; end
    checks++; if (nd != 0) begin
      failures++; $display("FAIL flush_prio_no_done got %0d want 0", nd); end
    run_op(1, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1, res, owd, owe, lat, st);
    checks++; if (res !== 32'hFFFF_FFFD || lat != 34) begin
      failures++; $display("FAIL flush_recover got %h lat %0d want fffffffd lat 34", res, lat); end
  endtask

  task automatic test_rst_mid();
    int nd;
    abort_mid(1'b1);
    @(negedge clk);
    op = 3'd7; r1 = 32'd100; r2 = 32'd7; rst = 1'b1; start4 = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; start4 = 1'b0;
    @(negedge clk);
    checks++; if (stall4 !== 1'b0) begin
      failures++; $display("FAIL rst_start_dropped_stall got %b want 0", stall4); end
    nd = 0;
    repeat (20) begin @(negedge clk); if (done4) nd++; end
    checks++; if (nd != 0) begin
      failures++; $display("FAIL rst_start_dropped got %0d done pulses want 0", nd); end
  endtask

  task automatic test_back_to_back();
    int nd, t[2];
    logic [31:0] rv[2]; logic [4:0] wv[2]; logic ev[2];
    nd = 0; t[0] = 0; t[1] = 0; rv[0] = '0; rv[1] = '0; wv[0] = '0; wv[1] = '0; ev[0] = 1'b0; ev[1] = 1'b0;
    @(negedge clk);
    op = 3'd5; r1 = 32'hFFFF_FFFF; r2 = 32'd3; wd = 5'd3; wreg = 1'b1; start4 = 1'b1;
    @(posedge clk);
    #1 op = 3'd7; r1 = 32'd100; r2 = 32'd7; wd = 5'd9; wreg = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 12) start4 = 1'b0;
      if (k == 10) begin
        checks++; if (stall4 !== 1'b0) begin
          failures++; $display("FAIL b2b_done_stall got %b want 0", stall4); end
      end
      if (k == 11) begin
        checks++; if (stall4 !== 1'b1) begin
          failures++; $display("FAIL b2b_reaccept_stall got %b want 1", stall4); end
      end
      if (done4) begin
        if (nd < 2) begin t[nd] = k; rv[nd] = wdata4; wv[nd] = wd4; ev[nd] = wreg4; end
        nd++;
      end
    end
    checks++; if (nd != 2 || t[0] != 10 || t[1] != 21) begin
      failures++; $display("FAIL b2b_timing got n=%0d t0=%0d t1=%0d want n=2 t0=10 t1=21", nd, t[0], t[1]); end
    checks++; if (rv[0] !== 32'h5555_5555 || wv[0] !== 5'd3 || ev[0] !== 1'b1) begin
      failures++; $display("FAIL b2b_op1 got %h/%0d/%b want 55555555/3/1", rv[0], wv[0], ev[0]); end
    checks++; if (rv[1] !== 32'd2 || wv[1] !== 5'd9 || ev[1] !== 1'b0) begin
      failures++; $display("FAIL b2b_op2 got %h/%0d/%b want 00000002/9/0", rv[1], wv[1], ev[1]); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_rst_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
